// File: rtl/rsa_cipher_tx.sv
// RSA ciphertext serial transmitter: 7-bit words are buffered in a FIFO and sent as async frames.
// Define RSA_TX_PARITY_EN to add an even-parity bit after the data bits.
module rsa_cipher_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] c_in,
  input  logic       c_valid,
  output logic       c_ready,
  output logic       tx,
  output logic       busy,
  output logic       ovf_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RSA_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_n;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop, load;

  logic [BW-1:0] baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic [6:0]    shift, shift_n;
  logic          tx_n, done;
`ifdef RSA_TX_PARITY_EN
  logic          par, par_n;
`endif

  assign c_ready = (count != CW'(FIFO_DEPTH));
  assign push    = c_valid && c_ready;
  assign done    = (baud == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= c_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (c_valid && !c_ready) ovf_err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    load    = 1'b0;
`ifdef RSA_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        load   = (count != '0);
      end
      START: begin
        if (done) begin
          state_n = DATA;
          baud_n  = '0;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (done) begin
          baud_n = '0;
          if (idx == 3'd6) begin
`ifdef RSA_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n   = idx + 1'b1;
            shift_n = {1'b0, shift[6:1]};
            tx_n    = shift[1];
          end
        end
      end
`ifdef RSA_TX_PARITY_EN
      PARITY: begin
        if (done) begin
          state_n = STOP;
          baud_n  = '0;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (done) begin
          baud_n = '0;
          if (count != '0) load = 1'b1;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Shared pop path: from IDLE, or straight out of STOP for gapless frames
    if (load) begin
      pop     = 1'b1;
      shift_n = mem[rptr];
      state_n = START;
      baud_n  = '0;
      idx_n   = '0;
      tx_n    = 1'b0;
`ifdef RSA_TX_PARITY_EN
      par_n   = ^mem[rptr];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
`ifdef RSA_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
      busy  <= (state_n != IDLE);
`ifdef RSA_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_rsa_cipher_tx.sv
// Scoreboard bench for rsa_cipher_tx: a serial receiver decodes tx
// and compares each frame against the queue of accepted words.
module tb_rsa_cipher_tx;

  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef RSA_TX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int FRAME = CPB * NB;
  localparam int LIM = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] c_in = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, tx, busy, ovf_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [6:0] q[$];

  rsa_cipher_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .c_in(c_in), .c_valid(c_valid),
    .c_ready(c_ready), .tx(tx), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic recv(output logic [6:0] d, output bit fr_ok,
                      output bit bz_ok, output int st, output bit got);
    int b;
    got = 0; fr_ok = 1; bz_ok = 1; st = 0; d = '0;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin got = 1; break; end
    end
    if (got) begin
      st = cyc;
      for (int o = 0; o < FRAME; o++) begin
        if (o > 0) @(negedge clk);
        if (busy !== 1'b1) bz_ok = 0;
        if (o % CPB == CPB / 2) begin
          b = o / CPB;
          if (b == 0) begin
            if (tx !== 1'b0) fr_ok = 0;
          end else if (b <= 7) begin
            d[b-1] = tx;
          end else if (b == NB - 1) begin
            if (tx !== 1'b1) fr_ok = 0;
          end else begin
            if (tx !== ^d) fr_ok = 0;
          end
        end
      end
    end
  endtask

  task automatic rx_check(input string nm, output int st);
    logic [6:0] d, e;
    bit fr, bz, got;
    recv(d, fr, bz, st, got);
    e = (q.size() > 0) ? q.pop_front() : 7'h7f;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no start bit, expected word %h", nm, e);
    end else begin
      checks += 2;
      if (d !== e) begin
        errors++;
        $display("FAIL %s data: got %h expected %h", nm, d, e);
      end
      if (!fr || !bz) begin
        errors++;
        $display("FAIL %s framing/busy: frame_ok=%0d busy_ok=%0d expected 1/1",
                 nm, fr, bz);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (c_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", c_ready); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", ovf_err); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int wc, st;
    c_in = 7'h55; c_valid = 1'b1;
    q.push_back(7'h55);
    @(posedge clk); #1;
    wc = cyc; c_valid = 1'b0;
    rx_check("single", st);
    checks++;
    if (st !== wc + 1) begin
      errors++; $display("FAIL single_latency start at %0d expected %0d", st, wc + 1);
    end
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b expected 0", busy); end
    if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_idle got %b expected 1", tx); end
    @(posedge clk); #1;
  endtask

`ifdef RSA_TX_PARITY_EN
  task automatic test_parity;
    int st;
    c_in = 7'h07; c_valid = 1'b1; q.push_back(7'h07);
    @(posedge clk); #1; c_valid = 1'b0;
    rx_check("parity_07", st);
    c_in = 7'h03; c_valid = 1'b1; q.push_back(7'h03);
    @(posedge clk); #1; c_valid = 1'b0;
    rx_check("parity_03", st);
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_overflow;
    logic [6:0] w [6] = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
    int st, lows;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          c_in = w[i]; c_valid = 1'b1;
          if (i < 5) q.push_back(w[i]);
          checks++;
          if (c_ready !== (i < 5)) begin
            errors++; $display("FAIL ovf_ready cycle %0d got %b expected %b", i, c_ready, i < 5);
          end
          @(posedge clk); #1;
        end
        c_valid = 1'b0;
        checks++;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b expected 1", ovf_err); end
      end
      begin
        for (int i = 0; i < 5; i++) rx_check("ovf_frame", st);
      end
    join
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks += 2;
    if (lows != 0) begin errors++; $display("FAIL ovf_dropped extra tx-low cycles %0d expected 0", lows); end
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", ovf_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int s1, s2;
    fork
      begin
        c_in = 7'h7f; c_valid = 1'b1; q.push_back(7'h7f);
        @(posedge clk); #1;
        c_in = 7'h00; q.push_back(7'h00);
        @(posedge clk); #1;
        c_valid = 1'b0;
      end
      begin
        rx_check("b2b_first", s1);
        rx_check("b2b_second", s2);
      end
    join
    checks++;
    if (s2 - s1 !== FRAME) begin
      errors++; $display("FAIL b2b_gap start spacing %0d expected %0d", s2 - s1, FRAME);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simul;
    int s, s1, s2, s3;
    fork
      begin
        c_in = 7'h21; c_valid = 1'b1; q.push_back(7'h21);
        @(posedge clk); #1;
        c_in = 7'h42; q.push_back(7'h42);
        @(posedge clk); #1;
        s = cyc; c_valid = 1'b0;
        for (int i = 0; i < LIM && cyc != s + FRAME - 1; i++) begin
          @(posedge clk); #1;
        end
        checks++;
        if (c_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b expected 1", c_ready); end
        c_in = 7'h63; c_valid = 1'b1; q.push_back(7'h63);
        @(posedge clk); #1;
        c_valid = 1'b0;
      end
      begin
        rx_check("simul_1", s1);
        rx_check("simul_2", s2);
        rx_check("simul_3", s3);
      end
    join
    checks++;
    if (s3 - s2 !== FRAME) begin
      errors++; $display("FAIL simul_gap start spacing %0d expected %0d", s3 - s2, FRAME);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lows, bz;
    c_valid = 1'b1;
    c_in = 7'h2a; @(posedge clk); #1;
    c_in = 7'h11; @(posedge clk); #1;
    c_in = 7'h22; @(posedge clk); #1;
    c_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b expected 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b expected 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    if (c_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b expected 1", c_ready); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b expected 0", ovf_err); end
    reset = 1'b0;
    lows = 0; bz = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) bz++;
    end
    checks++;
    if (lows != 0 || bz != 0) begin
      errors++; $display("FAIL rstmid_quiet tx_low=%0d busy=%0d expected 0/0", lows, bz);
    end
  endtask

  initial begin
    test_reset;
    test_single;
`ifdef RSA_TX_PARITY_EN
    test_parity;
`endif
    test_overflow;
    test_back_to_back;
    test_simul;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
